// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter: FSM states, spcon bit
// positions and field widths.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        GAP,
        DONE
    } arb_state_t;

    localparam int SPEN   = 0;
    localparam int CPHA   = 1;
    localparam int CPOL   = 2;

    localparam int LEN_W  = 4;
    localparam int BR_W   = 8;
    localparam int MODE_W = 2;

endpackage

// File: rtl/spi_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping modulo N. Returns a one-hot winner, its index and an any-valid flag.
module spi_rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N);
            if (!any && req_valid[cand]) begin
                any       = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between NUM_REQ requesters, sequencing multi-byte
// transactions byte by byte. Optional per-byte watchdog: SPI_ARB_TIMEOUT_EN.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [LEN_W*NUM_REQ-1:0]  req_len,
    input  logic [MODE_W*NUM_REQ-1:0] req_mode,
    input  logic [BR_W*NUM_REQ-1:0]   req_br,
    output logic [NUM_REQ-1:0]        req_gnt,
    input  logic [8*NUM_REQ-1:0]      tx_data,
    input  logic [NUM_REQ-1:0]        tx_valid,
    output logic [NUM_REQ-1:0]        tx_ready,
    output logic [7:0]                rx_data,
    output logic [NUM_REQ-1:0]        rx_valid,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [NUM_REQ-1:0]        ssn,
    output logic [7:0]                m_spcon,
    output logic [7:0]                m_spibr,
    output logic [7:0]                m_data,
    input  logic                      m_done,
    input  logic [7:0]                m_rx
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = 8;

    if (NUM_REQ < 2 || NUM_REQ > 4 || GAP_CYC < 0 || GAP_CYC > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("spi_arbiter: parameter out of range");
    end

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   owner, rr_ptr, next_ptr;
    logic [NUM_REQ-1:0] owner_oh;
    logic [LEN_W-1:0]   remaining;
    logic [MODE_W-1:0]  mode_q;
    logic [BR_W-1:0]    br_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               wd_expire;

    spi_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .gnt       (win_oh),
        .gnt_idx   (win_idx),
        .any       (win_any)
    );

    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign m_spibr  = br_q;

    always_comb begin
        state_nxt     = state;
        tx_ready      = '0;
        m_spcon       = '0;
        m_spcon[CPOL] = mode_q[1];
        m_spcon[CPHA] = mode_q[0];
        m_spcon[SPEN] = (state == START);
        case (state)
            IDLE: if (win_any) state_nxt = LOAD;
            LOAD: begin
                tx_ready = owner_oh;
                if (tx_valid[owner]) state_nxt = START;
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (m_done) begin
                    if (remaining == '0)  state_nxt = DONE;
                    else if (GAP_CYC == 0) state_nxt = LOAD;
                    else                   state_nxt = GAP;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            GAP:  if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nxt = LOAD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner config is latched at grant and deliberately left in place after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            owner_oh  <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            mode_q    <= '0;
            br_q      <= '0;
            gap_cnt   <= '0;
            m_data    <= '0;
            rx_data   <= '0;
            req_gnt   <= '0;
            rx_valid  <= '0;
            req_done  <= '0;
            ssn       <= '1;
        end else begin
            state    <= state_nxt;
            req_gnt  <= '0;
            rx_valid <= '0;
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        owner     <= win_idx;
                        owner_oh  <= win_oh;
                        remaining <= req_len[int'(win_idx)*LEN_W +: LEN_W];
                        mode_q    <= req_mode[int'(win_idx)*MODE_W +: MODE_W];
                        br_q      <= req_br[int'(win_idx)*BR_W +: BR_W];
                        req_gnt   <= win_oh;
                        ssn       <= ~win_oh;
                    end
                end
                LOAD: begin
                    if (tx_valid[owner]) m_data <= tx_data[int'(owner)*8 +: 8];
                end
                WAIT: begin
                    if (m_done) begin
                        rx_data  <= m_rx;
                        rx_valid <= owner_oh;
                        gap_cnt  <= '0;
                        if (remaining != '0) remaining <= remaining - 1'b1;
                    end else if (wd_expire) begin
                        ssn    <= '1;
                        rr_ptr <= next_ptr;
                    end
                end
                GAP: gap_cnt <= gap_cnt + 1'b1;
                DONE: begin
                    req_done <= owner_oh;
                    ssn      <= '1;
                    rr_ptr   <= next_ptr;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == WAIT) && !m_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog restarts for every byte; it only advances while waiting on the master.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            req_err <= '0;
        end else begin
            req_err <= '0;
            if (state != WAIT) wd_cnt <= '0;
            else               wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire) req_err <= owner_oh;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign req_err   = '0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter with a loopback spi_master model.
// Define SPI_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_spi_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 64;

    logic                   clk, rst;
    logic [NUM_REQ-1:0]     req_valid, req_gnt, tx_valid, tx_ready;
    logic [4*NUM_REQ-1:0]   req_len;
    logic [2*NUM_REQ-1:0]   req_mode;
    logic [8*NUM_REQ-1:0]   req_br, tx_data;
    logic [7:0]             rx_data, m_spcon, m_spibr, m_data, m_rx;
    logic [NUM_REQ-1:0]     rx_valid, req_done, req_err, ssn;
    logic                   m_done;

    spi_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_len(req_len), .req_mode(req_mode), .req_br(req_br),
        .req_gnt(req_gnt), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .req_done(req_done), .req_err(req_err),
        .ssn(ssn), .m_spcon(m_spcon), .m_spibr(m_spibr), .m_data(m_data),
        .m_done(m_done), .m_rx(m_rx)
    );

    typedef struct {
        int         r;
        int         len;
        logic [1:0] mode;
        logic [7:0] br;
        logic [7:0] b0;
        logic [7:0] step;
        int         stall;
        logic [7:0] exp_spcon;
        logic [7:0] exp_last_rx;
    } vec_t;

    int  cyc, checks, passed;
    bit  master_en;

    // Reference model: pending requests, round-robin pointer, per-requester payload.
    int         rr_m;
    bit         pend  [NUM_REQ];
    int         len_m [NUM_REQ];
    logic [1:0] mode_m[NUM_REQ];
    logic [7:0] br_m  [NUM_REQ];
    logic [7:0] dat_m [NUM_REQ][16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Loopback master: m_done arrives m_spibr+4 cycles after spen, m_rx echoes m_data.
    initial begin
        int         cnt;
        logic [7:0] cap;
        bit         busy;
        m_done = 1'b0;
        m_rx   = 8'h00;
        cnt    = 0;
        cap    = 8'h00;
        busy   = 1'b0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (busy) begin
                if (cnt <= 1) begin
                    m_done = master_en;
                    m_rx   = cap;
                    busy   = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (m_spcon[0]) begin
                busy = 1'b1;
                cnt  = int'(m_spibr) + 4;
                cap  = m_data;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        else             passed++;
    endtask

    task automatic bail(input string name);
        checks++;
        $display("[TB] FAIL %s: got no event within bound, expected event (cycle %0d)", name, cyc);
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "[TB] wait bound expired");
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    function automatic int expOwner();
        for (int i = 0; i < NUM_REQ; i++)
            if (pend[(rr_m + i) % NUM_REQ]) return (rr_m + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic post(input int r, input int len, input logic [1:0] mode, input logic [7:0] br,
                        input logic [7:0] b0, input logic [7:0] step);
        pend[r]   = 1'b1;
        len_m[r]  = len;
        mode_m[r] = mode;
        br_m[r]   = br;
        for (int k = 0; k < 16; k++) dat_m[r][k] = b0 + 8'(k) * step;
        req_valid[r]         = 1'b1;
        req_len[r*4 +: 4]    = 4'(len);
        req_mode[r*2 +: 2]   = mode;
        req_br[r*8 +: 8]     = br;
    endtask

    // Serves one whole transaction for whichever requester the model expects to win.
    task automatic applyStimulus(input int stall, input bit chk_lat,
                                 output logic [7:0] spcon_seen, output logic [7:0] last_rx);
        int                 owner, waited, viol, b, s_cyc, s_prev;
        logic [NUM_REQ-1:0] own_oh, ssn_low, all_hi;
        spcon_seen = '0;
        last_rx    = '0;
        s_prev     = 0;
        all_hi     = '1;
        waited     = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited > 60) begin bail("grant_wait"); return; end
        end while (req_gnt == '0);
        owner = expOwner();
        if (owner < 0) begin bail("grant_unexpected"); return; end
        own_oh  = oh(owner);
        ssn_low = ~own_oh;
        if (chk_lat) checkOutput("grant_latency", waited, 1);
        checkOutput("grant_owner", req_gnt, own_oh);
        checkOutput("grant_ssn", ssn, ssn_low);
        req_valid[owner] = 1'b0;
        pend[owner]      = 1'b0;
        b = int'(br_m[owner]) + 4;
        for (int k = 0; k <= len_m[owner]; k++) begin
            waited = 0;
            while (tx_ready == '0) begin
                @(negedge clk);
                waited++;
                if (waited > 60) begin bail("tx_ready_wait"); return; end
            end
            if (k == 0 && stall > 0) begin
                viol = 0;
                repeat (stall) begin
                    @(negedge clk);
                    if (ssn !== ssn_low || m_spcon[0] !== 1'b0 || tx_ready !== own_oh) viol++;
                end
                checkOutput("stall_hold", viol, 0);
            end
            checkOutput("tx_ready_owner", tx_ready, own_oh);
            tx_valid[owner]        = 1'b1;
            tx_data[owner*8 +: 8]  = dat_m[owner][k];
            @(negedge clk);
            tx_valid[owner] = 1'b0;
            s_cyc = cyc;
            if (k == 0) spcon_seen = m_spcon;
            checkOutput("spcon", m_spcon, {5'b0, mode_m[owner], 1'b1});
            checkOutput("spibr", m_spibr, br_m[owner]);
            checkOutput("m_data", m_data, dat_m[owner][k]);
            if (k > 0) checkOutput("spen_spacing", s_cyc - s_prev, b + GAP_CYC + 2);
            s_prev = s_cyc;
            waited = 0;
            viol   = 0;
            do begin
                @(negedge clk);
                waited++;
                if (waited > 300) begin bail("rx_valid_wait"); return; end
                if (rx_valid == '0 && (m_spcon[0] || req_done != '0 || ssn !== ssn_low)) viol++;
            end while (rx_valid == '0);
            checkOutput("wait_quiet", viol, 0);
            checkOutput("rx_valid", rx_valid, own_oh);
            checkOutput("rx_data", rx_data, dat_m[owner][k]);
            checkOutput("rx_latency", cyc - s_cyc, b + 1);
            last_rx = rx_data;
            if (k < len_m[owner]) checkOutput("no_early_done", req_done, 0);
        end
        @(negedge clk);
        checkOutput("req_done", req_done, own_oh);
        checkOutput("done_ssn", ssn, all_hi);
        checkOutput("done_no_err", req_err, 0);
        rr_m = (owner + 1) % NUM_REQ;
    endtask

    initial begin
        vec_t               tbl[5];
        logic [7:0]         sp, lr;
        logic [NUM_REQ-1:0] all_hi, own_oh;
        int                 waited, viol, owner, s_cyc;

        checks = 0; passed = 0; master_en = 1'b1; rr_m = 0; all_hi = '1;
        for (int r = 0; r < NUM_REQ; r++) pend[r] = 1'b0;
        rst = 1'b1; req_valid = '0; req_len = '0; req_mode = '0; req_br = '0;
        tx_valid = '0; tx_data = '0;

        tbl[0] = '{r: 0, len: 0, mode: 2'b01, br: 8'd3, b0: 8'hA5, step: 8'h00, stall: 0,  exp_spcon: 8'h03, exp_last_rx: 8'hA5};
        tbl[1] = '{r: 1, len: 2, mode: 2'b00, br: 8'd1, b0: 8'h11, step: 8'h11, stall: 0,  exp_spcon: 8'h01, exp_last_rx: 8'h33};
        tbl[2] = '{r: 0, len: 0, mode: 2'b11, br: 8'd0, b0: 8'h3C, step: 8'h00, stall: 20, exp_spcon: 8'h07, exp_last_rx: 8'h3C};
        tbl[3] = '{r: 1, len: 1, mode: 2'b10, br: 8'd2, b0: 8'hF0, step: 8'h01, stall: 0,  exp_spcon: 8'h05, exp_last_rx: 8'hF1};
        tbl[4] = '{r: 0, len: 3, mode: 2'b01, br: 8'd0, b0: 8'h80, step: 8'h10, stall: 0,  exp_spcon: 8'h03, exp_last_rx: 8'hB0};

        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_ssn", ssn, all_hi);
        checkOutput("rst_spcon", m_spcon, 0);
        checkOutput("rst_spibr", m_spibr, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        checkOutput("rst_pulses", {req_gnt, tx_ready, rx_valid, req_done, req_err}, 0);
        rst = 1'b0;

        $display("[TB] simultaneous requests from reset");
        post(0, 0, 2'b01, 8'd3, 8'hA5, 8'h00);
        post(1, 2, 2'b00, 8'd1, 8'h11, 8'h11);
        applyStimulus(0, 1'b1, sp, lr);
        applyStimulus(0, 1'b0, sp, lr);
        post(0, 0, 2'b10, 8'd2, 8'h5A, 8'h00);
        applyStimulus(0, 1'b1, sp, lr);
        post(0, 1, 2'b01, 8'd1, 8'h21, 8'h01);
        post(1, 0, 2'b11, 8'd0, 8'h42, 8'h00);
        applyStimulus(0, 1'b1, sp, lr);
        applyStimulus(0, 1'b0, sp, lr);

        $display("[TB] vector table");
        for (int i = 0; i < 5; i++) begin
            post(tbl[i].r, tbl[i].len, tbl[i].mode, tbl[i].br, tbl[i].b0, tbl[i].step);
            applyStimulus(tbl[i].stall, 1'b1, sp, lr);
            checkOutput("table_spcon", sp, tbl[i].exp_spcon);
            checkOutput("table_last_rx", lr, tbl[i].exp_last_rx);
        end

        $display("[TB] reset during byte 2 of 4");
        post(1, 3, 2'b10, 8'd1, 8'h40, 8'h01);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited > 60) bail("rst_grant_wait");
        end while (req_gnt == '0);
        req_valid[1] = 1'b0;
        pend[1]      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            waited = 0;
            while (tx_ready == '0) begin
                @(negedge clk);
                waited++;
                if (waited > 60) bail("rst_tx_wait");
            end
            tx_valid[1] = 1'b1;
            tx_data[15:8] = dat_m[1][k];
            @(negedge clk);
            tx_valid[1] = 1'b0;
            if (k == 0) begin
                waited = 0;
                while (rx_valid == '0) begin
                    @(negedge clk);
                    waited++;
                    if (waited > 60) bail("rst_rx_wait");
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ssn", ssn, all_hi);
        checkOutput("midrst_spcon", m_spcon, 0);
        checkOutput("midrst_no_done", {req_done, req_err, rx_valid}, 0);
        viol = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_valid != '0 || req_done != '0 || req_gnt != '0 || ssn !== all_hi || tx_ready != '0) viol++;
        end
        checkOutput("midrst_quiet", viol, 0);
        rr_m = 0;
        post(0, 0, 2'b00, 8'd1, 8'h0F, 8'h00);
        post(1, 1, 2'b01, 8'd2, 8'hC3, 8'h11);
        applyStimulus(0, 1'b1, sp, lr);
        applyStimulus(0, 1'b0, sp, lr);

`ifdef SPI_ARB_TIMEOUT_EN
        $display("[TB] watchdog abort");
        master_en = 1'b0;
        post(0, 0, 2'b01, 8'd1, 8'h99, 8'h00);
        post(1, 0, 2'b10, 8'd1, 8'h66, 8'h00);
        owner  = expOwner();
        own_oh = oh(owner);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited > 60) bail("wd_grant_wait");
        end while (req_gnt == '0);
        checkOutput("wd_grant_owner", req_gnt, own_oh);
        req_valid[owner] = 1'b0;
        pend[owner]      = 1'b0;
        tx_valid[owner]       = 1'b1;
        tx_data[owner*8 +: 8] = dat_m[owner][0];
        @(negedge clk);
        tx_valid[owner] = 1'b0;
        s_cyc  = cyc;
        waited = 0;
        viol   = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited > 300) bail("wd_err_wait");
            if (rx_valid != '0 || req_done != '0) viol++;
        end while (req_err == '0);
        checkOutput("wd_err_owner", req_err, own_oh);
        checkOutput("wd_err_latency", cyc - s_cyc, TIMEOUT_CYC + 1);
        checkOutput("wd_ssn", ssn, all_hi);
        checkOutput("wd_no_rx_done", viol, 0);
        rr_m = (owner + 1) % NUM_REQ;
        master_en = 1'b1;
        applyStimulus(0, 1'b0, sp, lr);
`endif

        $display("[TB] randomized transactions");
        for (int t = 0; t < 8; t++) begin
            int mask;
            mask = int'($urandom_range(1, 3));
            for (int r = 0; r < NUM_REQ; r++)
                if (mask[r]) post(r, int'($urandom_range(0, 3)), 2'($urandom), 8'($urandom_range(0, 3)),
                                  8'($urandom), 8'($urandom));
            while (expOwner() >= 0) applyStimulus(0, 1'b0, sp, lr);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
